ajit_acc_mem_arbiter: RTL and testbench
=======================================

AJIT_ACC_MEM_ARBITER -- requirements
Module: ajit_acc_mem_arbiter

Interface
REQ-001 Parameter: ID_FIFO_DEPTH, default 4, max outstanding memory requests (power of 2, >=2).
REQ-002 One clock; reset is synchronous and active-low: clk input 1, rising-edge clock; reset input 1, synchronous active-low reset (0 = reset).
REQ-003 REQ0_pipe_write_req input 1, write_ack output 1, write_data input 110: requester 0 memory request (ACB request format).
REQ-004 RESP0_pipe_read_req input 1, read_ack output 1, read_data output 65: requester 0 memory response.
REQ-005 REQ1_* / RESP1_* identical to REQ-003/004 for requester 1.
REQ-006 ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data output 110, read_req input 1, read_ack output 1: shared memory request pipe.
REQ-007 ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data input 65, write_req input 1, write_ack output 1: shared memory response pipe.
REQ-008 A pipe transfer SHALL occur only in a cycle where its req and ack are both 1.

Function
REQ-009 Request FSM SHALL have states IDLE and ISSUE.
REQ-010 IDLE: REQx_write_ack = 1 only for the granted requester, and only when the ID FIFO is not full; all other acks 0.
REQ-011 Grant SHALL be round-robin: with both requesting, grant the requester not served last; after reset, requester 0 has priority.
REQ-012 Single requester asserting SHALL be granted in the same cycle, regardless of priority.
REQ-013 On transfer: latch the 110-bit data, push requester ID (0/1) into the ID FIFO, flip priority, go to ISSUE.
REQ-014 ISSUE: ACB request read_ack = 1 with the latched data; when read_req = 1, transfer, return to IDLE next cycle; latency accept-to-ACB-valid = 1 cycle.
REQ-015 Both REQx_write_ack SHALL be 0 in ISSUE (one request in flight on the ACB request pipe at a time).
REQ-016 Response path: ACB response write_ack = 1 when response holding register empty and ID FIFO not empty; 0 otherwise.
REQ-017 On ACB response transfer: capture the 65-bit data, route to RESP<head ID>: assert its read_ack with the data next cycle.
REQ-018 On RESPx transfer: pop ID FIFO, clear holding register; response pipe free the following cycle.
REQ-019 Responses SHALL be returned in issue order; no reordering.
REQ-020 ID FIFO full: no new request grants; a pop and push in the same cycle SHALL both occur and occupancy stays unchanged.
REQ-021 ACB response arriving with ID FIFO empty SHALL not be acked (write_ack = 0).
REQ-022 Response data SHALL be passed unmodified, bit 64 included.

Reset
REQ-023 On reset = 0 at clk edge: FSM to IDLE, ID FIFO emptied, holding registers cleared, priority to requester 0.
REQ-024 During reset and the cycle after, all ack outputs = 0, all data outputs = 0.
REQ-025 Reset mid-transaction SHALL discard in-flight requests/responses; no transfer completes in a reset cycle.

Configuration
REQ-026 Macro AJIT_ACC_MEM_ARB_STATS_EN: when defined, add outputs grant_count0, grant_count1 (16 bits each), incremented per REQx transfer, saturating at 16'hFFFF, cleared by reset.
REQ-027 Without AJIT_ACC_MEM_ARB_STATS_EN those ports and counters SHALL not exist; other behaviour identical.

Structure
REQ-028 Package ajit_acc_pkg SHALL hold ACB request width (110), response width (65), requester ID type, FSM state encoding.
REQ-029 ID FIFO SHALL be a sub-module acc_id_fifo (depth ID_FIFO_DEPTH, 1-bit data, full/empty flags).

Verification
REQ-030 Single request: REQ0 data 110'h1234, ACB read_req held 1 -> ACB read_ack at cycle+1 with 110'h1234; ACB response 65'h0_DEAD_BEEF -> RESP0 read_ack with 65'h0_DEAD_BEEF, RESP1 read_ack stays 0.
REQ-031 Contention: REQ0 and REQ1 held 1 for 4 requests -> grant order 0,1,0,1; responses routed 0,1,0,1.
REQ-032 Back-pressure: ACB read_req = 0 for 10 cycles in ISSUE -> read_ack and data stable, both REQx_write_ack = 0.
REQ-033 FIFO full: 4 requests issued, no responses -> 5th REQ1 request not acked until first RESP transfer, then acked.
REQ-034 Reset mid-flight: reset = 0 in ISSUE with 2 outstanding -> all acks 0, FIFO empty, next grant to requester 0.
REQ-035 Stats (macro on): 70000 REQ0 transfers -> grant_count0 = 16'hFFFF, grant_count1 = 0.

Source files
------------

// File: rtl/ajit_acc_pkg.sv
// Shared types and constants for the accelerator memory arbiter.
// - AcbReqWidth / AcbRespWidth : ACB request and response word widths
// - req_id_t                   : requester identifier (0 or 1)
// - req_state_e                : request-side FSM encoding
// - rr_pick                    : round-robin choice between two requesters
package ajit_acc_pkg;

  localparam int unsigned AcbReqWidth  = 110;
  localparam int unsigned AcbRespWidth = 65;

  typedef logic req_id_t;

  typedef enum logic {
    StIdle  = 1'b0,
    StIssue = 1'b1
  } req_state_e;

  // With both requesting, serve the one not served last; otherwise whoever asks.
  function automatic req_id_t rr_pick(logic req0, logic req1, req_id_t last);
    if (req0 && req1) begin
      return ~last;
    end
    return req1 ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/ajit_acc_mem_arbiter_if.sv
// Pipe bundle between two requesters, the shared ACB memory pipes and the arbiter.
// Every pipe moves a word only in a cycle where its req and ack are both high.
// - REQx_*  : requester x memory request (write side of the arbiter)
// - RESPx_* : requester x memory response (read side of the arbiter)
// - ACB_ACCELERATOR_MEM_REQUEST_*  : shared request pipe toward memory
// - ACB_ACCELERATOR_MEM_RESPONSE_* : shared response pipe from memory
// Modport slave is the arbiter; modport master is its environment.
interface ajit_acc_mem_arbiter_if;
  import ajit_acc_pkg::*;

  logic                    REQ0_pipe_write_req;
  logic                    REQ0_pipe_write_ack;
  logic [AcbReqWidth-1:0]  REQ0_pipe_write_data;
  logic                    REQ1_pipe_write_req;
  logic                    REQ1_pipe_write_ack;
  logic [AcbReqWidth-1:0]  REQ1_pipe_write_data;

  logic                    RESP0_pipe_read_req;
  logic                    RESP0_pipe_read_ack;
  logic [AcbRespWidth-1:0] RESP0_pipe_read_data;
  logic                    RESP1_pipe_read_req;
  logic                    RESP1_pipe_read_ack;
  logic [AcbRespWidth-1:0] RESP1_pipe_read_data;

  logic                    ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req;
  logic                    ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack;
  logic [AcbReqWidth-1:0]  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data;

  logic                    ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req;
  logic                    ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack;
  logic [AcbRespWidth-1:0] ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data;

  modport slave (
    input  REQ0_pipe_write_req, REQ0_pipe_write_data,
    output REQ0_pipe_write_ack,
    input  REQ1_pipe_write_req, REQ1_pipe_write_data,
    output REQ1_pipe_write_ack,
    input  RESP0_pipe_read_req,
    output RESP0_pipe_read_ack, RESP0_pipe_read_data,
    input  RESP1_pipe_read_req,
    output RESP1_pipe_read_ack, RESP1_pipe_read_data,
    input  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
    output ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack, ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data,
    input  ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req, ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
    output ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack
  );

  modport master (
    output REQ0_pipe_write_req, REQ0_pipe_write_data,
    input  REQ0_pipe_write_ack,
    output REQ1_pipe_write_req, REQ1_pipe_write_data,
    input  REQ1_pipe_write_ack,
    output RESP0_pipe_read_req,
    input  RESP0_pipe_read_ack, RESP0_pipe_read_data,
    output RESP1_pipe_read_req,
    input  RESP1_pipe_read_ack, RESP1_pipe_read_data,
    output ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
    input  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack, ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data,
    output ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req, ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
    input  ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack
  );

endinterface

// File: rtl/acc_id_fifo.sv
// Requester-ID FIFO: remembers which requester owns each outstanding memory request
// so responses are routed back in issue order.
// Ports: clk_i, rst_ni (synchronous, active-low), push_i/data_i (enqueue an ID),
// pop_i (dequeue head), data_o (head ID), full_o, empty_o.
// Depth must be a power of two (pointers wrap naturally).
module acc_id_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Depth-1:0] mem_q, mem_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ajit_acc_mem_arbiter.sv
// Two-requester arbiter onto a shared ACB memory request/response pipe pair.
// Requests are granted round-robin, forwarded one at a time, and responses are
// routed back in issue order using an ID FIFO of ID_FIFO_DEPTH entries.
// Ports: clk (rising edge), reset (synchronous, active-low), bus (pipe bundle, slave).
// Optional macro AJIT_ACC_MEM_ARB_STATS_EN adds grant_count0/grant_count1: saturating
// 16-bit per-requester grant counters, cleared by reset.
module ajit_acc_mem_arbiter
  import ajit_acc_pkg::*;
#(
  parameter int unsigned ID_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  ajit_acc_mem_arbiter_if.slave bus
`ifdef AJIT_ACC_MEM_ARB_STATS_EN
  ,
  output logic [15:0]           grant_count0,
  output logic [15:0]           grant_count1
`endif
);

  req_state_e              state_q, state_d;
  req_id_t                 last_q, last_d;
  logic [AcbReqWidth-1:0]  req_data_q, req_data_d;
  logic                    hold_valid_q, hold_valid_d;
  logic [AcbRespWidth-1:0] hold_data_q, hold_data_d;
  logic                    live_q;

  logic    en;
  req_id_t grant_id;
  logic    ack0, ack1;
  logic    push, pop;
  logic    fifo_full, fifo_empty, fifo_head;
  logic    resp_wack, resp0_ack, resp1_ack;

  // live_q holds all acks low for the cycle following reset release.
  assign en = reset && live_q;

  acc_id_fifo #(
    .Depth (ID_FIFO_DEPTH)
  ) u_id_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .data_i  (grant_id),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Request side.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    req_data_d = req_data_q;
    ack0       = 1'b0;
    ack1       = 1'b0;
    push       = 1'b0;
    grant_id   = rr_pick(bus.REQ0_pipe_write_req, bus.REQ1_pipe_write_req, last_q);
    bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack  = 1'b0;
    bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data = '0;
    unique case (state_q)
      StIdle: begin
        // rr_pick only names a requester that is asking, so ack implies a transfer.
        if (en && !fifo_full && (bus.REQ0_pipe_write_req || bus.REQ1_pipe_write_req)) begin
          ack0       = (grant_id == 1'b0);
          ack1       = (grant_id == 1'b1);
          push       = 1'b1;
          last_d     = grant_id;
          req_data_d = grant_id ? bus.REQ1_pipe_write_data : bus.REQ0_pipe_write_data;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (en) begin
          bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack  = 1'b1;
          bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data = req_data_q;
          if (bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.REQ0_pipe_write_ack = ack0;
  assign bus.REQ1_pipe_write_ack = ack1;

  // Response side: one holding register, routed to the FIFO head's requester.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    pop          = 1'b0;
    resp_wack    = en && !hold_valid_q && !fifo_empty;
    resp0_ack    = en && hold_valid_q && (fifo_head == 1'b0);
    resp1_ack    = en && hold_valid_q && (fifo_head == 1'b1);
    if (resp_wack && bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req) begin
      hold_valid_d = 1'b1;
      hold_data_d  = bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data;
    end
    if ((resp0_ack && bus.RESP0_pipe_read_req) || (resp1_ack && bus.RESP1_pipe_read_req)) begin
      pop          = 1'b1;
      hold_valid_d = 1'b0;
      hold_data_d  = '0;
    end
  end

  assign bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack = resp_wack;
  assign bus.RESP0_pipe_read_ack  = resp0_ack;
  assign bus.RESP1_pipe_read_ack  = resp1_ack;
  assign bus.RESP0_pipe_read_data = resp0_ack ? hold_data_q : '0;
  assign bus.RESP1_pipe_read_data = resp1_ack ? hold_data_q : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_q       <= 1'b1;  // requester 0 wins the first contention
      req_data_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      req_data_q   <= req_data_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      live_q       <= 1'b1;
    end
  end

`ifdef AJIT_ACC_MEM_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (ack0 && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
    if (ack1 && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_count0 = cnt0_q;
  assign grant_count1 = cnt1_q;
`endif

endmodule

// File: tb/tb_ajit_acc_mem_arbiter.sv
module tb_ajit_acc_mem_arbiter;
  import ajit_acc_pkg::*;

  localparam int unsigned Depth = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ajit_acc_mem_arbiter_if bus ();

`ifdef AJIT_ACC_MEM_ARB_STATS_EN
  logic [15:0] grant_count0, grant_count1;
`endif

  ajit_acc_mem_arbiter #(
    .ID_FIFO_DEPTH (Depth)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus)
`ifdef AJIT_ACC_MEM_ARB_STATS_EN
    ,
    .grant_count0 (grant_count0),
    .grant_count1 (grant_count1)
`endif
  );

  // Transaction-level reference: one request may be in flight toward memory, the
  // owners of outstanding requests form a queue, one response may be parked.
  bit                      m_busy, m_hold, m_ready, m_init;
  logic [AcbReqWidth-1:0]  m_data;
  logic [AcbRespWidth-1:0] m_hdata;
  int                      m_last = 1;
  int                      m_ids[$];
  int                      m_cnt0, m_cnt1;
  int                      grants[$];
  int                      routes[$];
  int                      n_g0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AcbReqWidth-1:0] rnd_req();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[AcbReqWidth-1:0];
  endfunction

  function automatic logic [AcbRespWidth-1:0] rnd_resp();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[AcbRespWidth-1:0];
  endfunction

  task automatic settle();
    #1;
  endtask

  // Check every output against the reference, advance one clock, update the reference.
  task automatic cycle();
    logic en, e_wa0, e_wa1, e_acb, e_rwa, e_ra0, e_ra1;
    int   g;
    #1;
    en = reset && m_ready;
    if (bus.REQ0_pipe_write_req && bus.REQ1_pipe_write_req) g = (m_last == 0) ? 1 : 0;
    else g = bus.REQ1_pipe_write_req ? 1 : 0;
    e_wa0 = en && !m_busy && (m_ids.size() < Depth) && bus.REQ0_pipe_write_req && (g == 0);
    e_wa1 = en && !m_busy && (m_ids.size() < Depth) && bus.REQ1_pipe_write_req && (g == 1);
    e_acb = en && m_busy;
    e_rwa = en && !m_hold && (m_ids.size() > 0);
    e_ra0 = en && m_hold && (m_ids.size() > 0) && (m_ids[0] == 0);
    e_ra1 = en && m_hold && (m_ids.size() > 0) && (m_ids[0] == 1);
    chk("req0_wack", 128'(bus.REQ0_pipe_write_ack), 128'(e_wa0));
    chk("req1_wack", 128'(bus.REQ1_pipe_write_ack), 128'(e_wa1));
    chk("acb_req_rack", 128'(bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack), 128'(e_acb));
    chk("acb_req_data", 128'(bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data),
        e_acb ? 128'(m_data) : 128'd0);
    chk("acb_resp_wack", 128'(bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack), 128'(e_rwa));
    chk("resp0_rack", 128'(bus.RESP0_pipe_read_ack), 128'(e_ra0));
    chk("resp1_rack", 128'(bus.RESP1_pipe_read_ack), 128'(e_ra1));
    chk("resp0_data", 128'(bus.RESP0_pipe_read_data), e_ra0 ? 128'(m_hdata) : 128'd0);
    chk("resp1_data", 128'(bus.RESP1_pipe_read_data), e_ra1 ? 128'(m_hdata) : 128'd0);
`ifdef AJIT_ACC_MEM_ARB_STATS_EN
    if (m_init) begin
      chk("grant_count0", 128'(grant_count0), 128'(m_cnt0));
      chk("grant_count1", 128'(grant_count1), 128'(m_cnt1));
    end
`endif
    // Observed handshakes, for order checks.
    if (bus.REQ0_pipe_write_ack && bus.REQ0_pipe_write_req) begin grants.push_back(0); n_g0++; end
    if (bus.REQ1_pipe_write_ack && bus.REQ1_pipe_write_req) grants.push_back(1);
    if (bus.RESP0_pipe_read_ack && bus.RESP0_pipe_read_req) routes.push_back(0);
    if (bus.RESP1_pipe_read_ack && bus.RESP1_pipe_read_req) routes.push_back(1);
    @(posedge clk);
    if (!reset) begin
      m_busy = 0; m_hold = 0; m_last = 1; m_ids.delete(); m_cnt0 = 0; m_cnt1 = 0;
    end else begin
      if ((e_ra0 && bus.RESP0_pipe_read_req) || (e_ra1 && bus.RESP1_pipe_read_req)) begin
        void'(m_ids.pop_front());
        m_hold = 0;
      end
      if (e_rwa && bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req) begin
        m_hold  = 1;
        m_hdata = bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data;
      end
      if (e_acb && bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req) m_busy = 0;
      if (e_wa0) begin
        m_ids.push_back(0); m_busy = 1; m_data = bus.REQ0_pipe_write_data; m_last = 0;
        if (m_cnt0 < 65535) m_cnt0++;
      end
      if (e_wa1) begin
        m_ids.push_back(1); m_busy = 1; m_data = bus.REQ1_pipe_write_data; m_last = 1;
        if (m_cnt1 < 65535) m_cnt1++;
      end
    end
    m_ready = reset;
    m_init  = 1;
    #1;
  endtask

  task automatic clear_inputs();
    bus.REQ0_pipe_write_req = 0;  bus.REQ0_pipe_write_data = '0;
    bus.REQ1_pipe_write_req = 0;  bus.REQ1_pipe_write_data = '0;
    bus.RESP0_pipe_read_req = 0;  bus.RESP1_pipe_read_req = 0;
    bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req   = 0;
    bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req = 0;
    bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    clear_inputs();
    cycle();
    cycle();
    reset = 1;
    cycle();
    grants.delete();
    routes.delete();
  endtask

  initial begin
    logic [AcbReqWidth-1:0] saved;

    // Reset state; a request in the first cycle after release is not acked.
    clear_inputs();
    reset = 0;
    settle();
    chk("rst_acb_rack", 128'(bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack), 128'd0);
    cycle();
    cycle();
    reset = 1;
    bus.REQ0_pipe_write_req = 1;
    settle();
    chk("post_rst_req0_wack", 128'(bus.REQ0_pipe_write_ack), 128'd0);
    cycle();

    // Single request and response.
    do_reset();
    bus.REQ0_pipe_write_req  = 1;
    bus.REQ0_pipe_write_data = 110'h1234;
    bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req = 1;
    settle();
    chk("single_req0_wack", 128'(bus.REQ0_pipe_write_ack), 128'd1);
    chk("single_acb_idle", 128'(bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack), 128'd0);
    cycle();
    bus.REQ0_pipe_write_req = 0;
    settle();
    chk("single_acb_rack", 128'(bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack), 128'd1);
    chk("single_acb_data", 128'(bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data), 128'h1234);
    cycle();
    bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req  = 1;
    bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data = 65'h0_DEAD_BEEF;
    settle();
    chk("single_resp_wack", 128'(bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack), 128'd1);
    cycle();
    bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req = 0;
    bus.RESP0_pipe_read_req = 1;
    bus.RESP1_pipe_read_req = 1;
    settle();
    chk("single_resp0_rack", 128'(bus.RESP0_pipe_read_ack), 128'd1);
    chk("single_resp0_data", 128'(bus.RESP0_pipe_read_data), 128'h0_DEAD_BEEF);
    chk("single_resp1_rack", 128'(bus.RESP1_pipe_read_ack), 128'd0);
    cycle();
    clear_inputs();
    cycle();

    // Contention: both held for four requests.
    do_reset();
    bus.REQ0_pipe_write_req = 1;
    bus.REQ1_pipe_write_req = 1;
    bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req   = 1;
    bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req = 1;
    bus.RESP0_pipe_read_req = 1;
    bus.RESP1_pipe_read_req = 1;
    for (int i = 0; i < 40 && grants.size() < 4; i++) begin
      bus.REQ0_pipe_write_data = rnd_req();
      bus.REQ1_pipe_write_data = rnd_req();
      bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data = rnd_resp();
      cycle();
    end
    bus.REQ0_pipe_write_req = 0;
    bus.REQ1_pipe_write_req = 0;
    for (int i = 0; i < 40 && routes.size() < 4; i++) begin
      bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data = rnd_resp();
      cycle();
    end
    chk("rr_grant_count", 128'(grants.size()), 128'd4);
    chk("rr_route_count", 128'(routes.size()), 128'd4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant_order", 128'(grants[k]), 128'(k % 2));
      chk("rr_route_order", 128'(routes[k]), 128'(k % 2));
    end
    clear_inputs();
    cycle();

    // Back-pressure on the ACB request pipe.
    do_reset();
    saved = rnd_req();
    bus.REQ0_pipe_write_req  = 1;
    bus.REQ0_pipe_write_data = saved;
    cycle();
    bus.REQ0_pipe_write_data = rnd_req();
    bus.REQ1_pipe_write_req  = 1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("bp_acb_rack", 128'(bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack), 128'd1);
      chk("bp_acb_data", 128'(bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data), 128'(saved));
      chk("bp_req_wacks", 128'({bus.REQ0_pipe_write_ack, bus.REQ1_pipe_write_ack}), 128'd0);
      cycle();
    end
    bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req = 1;
    bus.REQ1_pipe_write_req = 0;
    cycle();
    clear_inputs();
    cycle();

    // ID FIFO full: fifth request waits for the first response to leave.
    do_reset();
    bus.REQ0_pipe_write_req = 1;
    bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req = 1;
    for (int i = 0; i < 20 && grants.size() < 4; i++) begin
      bus.REQ0_pipe_write_data = rnd_req();
      cycle();
    end
    bus.REQ0_pipe_write_req = 0;
    bus.REQ1_pipe_write_req = 1;
    bus.REQ1_pipe_write_data = rnd_req();
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("full_req1_wack", 128'(bus.REQ1_pipe_write_ack), 128'd0);
      cycle();
    end
    bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req  = 1;
    bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data = rnd_resp();
    cycle();
    bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req = 0;
    bus.RESP0_pipe_read_req = 1;
    settle();
    chk("full_pop_cycle_wack", 128'(bus.REQ1_pipe_write_ack), 128'd0);
    cycle();
    bus.RESP0_pipe_read_req = 0;
    settle();
    chk("full_after_pop_wack", 128'(bus.REQ1_pipe_write_ack), 128'd1);
    cycle();
    clear_inputs();
    cycle();

    // Reset while a request sits in ISSUE with two outstanding.
    do_reset();
    bus.REQ0_pipe_write_req = 1;
    bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req = 1;
    for (int i = 0; i < 20 && grants.size() < 2; i++) begin
      bus.REQ0_pipe_write_data = rnd_req();
      cycle();
    end
    bus.REQ0_pipe_write_req = 0;
    bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req = 0;
    cycle();
    settle();
    chk("mid_issue_rack", 128'(bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack), 128'd1);
    reset = 0;
    bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req = 1;
    settle();
    chk("mid_rst_acb_rack", 128'(bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack), 128'd0);
    chk("mid_rst_acb_data", 128'(bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data), 128'd0);
    cycle();
    cycle();
    reset = 1;
    bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req = 0;
    cycle();
    bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req = 1;
    bus.REQ0_pipe_write_req = 1;
    bus.REQ1_pipe_write_req = 1;
    settle();
    chk("mid_fifo_empty_wack", 128'(bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack), 128'd0);
    chk("mid_next_grant", 128'({bus.REQ1_pipe_write_ack, bus.REQ0_pipe_write_ack}), 128'b01);
    cycle();
    clear_inputs();
    cycle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      bus.REQ0_pipe_write_req  = 1'($urandom());
      bus.REQ1_pipe_write_req  = 1'($urandom());
      bus.REQ0_pipe_write_data = rnd_req();
      bus.REQ1_pipe_write_data = rnd_req();
      bus.RESP0_pipe_read_req  = 1'($urandom());
      bus.RESP1_pipe_read_req  = 1'($urandom());
      bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req    = 1'($urandom());
      bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req  = 1'($urandom());
      bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data = rnd_resp();
      cycle();
    end
    reset = 1;

`ifdef AJIT_ACC_MEM_ARB_STATS_EN
    // Saturation of the grant counter.
    do_reset();
    n_g0 = 0;
    bus.REQ0_pipe_write_req = 1;
    bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req   = 1;
    bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req = 1;
    bus.RESP0_pipe_read_req = 1;
    for (int i = 0; i < 160000 && n_g0 < 70000; i++) begin
      grants.delete();
      routes.delete();
      cycle();
    end
    chk("stats_transfers", 128'(n_g0), 128'd70000);
    chk("stats_sat0", 128'(grant_count0), 128'hFFFF);
    chk("stats_cnt1", 128'(grant_count1), 128'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
